// File: rtl/multicore_io_scheduler_pkg.sv
// multicore_io_scheduler_pkg: phase encoding and default settings shared by the I/O scheduler files
package multicore_io_scheduler_pkg;
  typedef enum logic [1:0] {PH_INPUT = 2'd0, PH_OUTPUT = 2'd1, PH_FINISHED = 2'd2} phase_e;
  localparam int OPS_PER_CORE_DEF = 5;
  localparam logic [7:0] FINISH_PATTERN_DEF = 8'hA5;
endpackage

// File: rtl/multicore_io_scheduler_if.sv
// multicore_io_scheduler_if: board pins and per-core buses around the I/O scheduler
// master = board/cores side (drives SW_pin, Done_core, Display_core), slave = scheduler side
interface multicore_io_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int SW_W = 5,
  parameter int DISP_W = 8
);
  logic [SW_W-1:0] SW_pin;
  logic [NUM_CORES-1:0] Done_core;
  logic [NUM_CORES*DISP_W-1:0] Display_core;
  logic [NUM_CORES*SW_W-1:0] SW_core;
  logic [DISP_W-1:0] Display_pin;
  logic [2:0] Active_core;
  logic [1:0] Phase;
  logic [7:0] Ops_left;
  modport master (output SW_pin, Done_core, Display_core, input SW_core, Display_pin, Active_core, Phase, Ops_left);
  modport slave (input SW_pin, Done_core, Display_core, output SW_core, Display_pin, Active_core, Phase, Ops_left);
endinterface

// File: rtl/multicore_io_scheduler_button_debouncer.sv
// button_debouncer: 2-flop sync, stability counter and one-cycle pulse on a debounced 1->0 edge
// Ports: Clock_pin, Resetn_pin (sync, active-low), btn_pin (raw button), press (registered pulse)
module button_debouncer #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic Clock_pin,
  input  logic Resetn_pin,
  input  logic btn_pin,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic m, s, db;
  logic [CW-1:0] cnt;
  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      m <= 1'b0;
      s <= 1'b0;
      db <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      m <= btn_pin;
      s <= m;
      press <= 1'b0;
      if (s == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        db <= s;
        cnt <= '0;
        press <= db & ~s;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/multicore_io_scheduler.sv
// multicore_io_scheduler: shares one switch bank and LED display among cores, round-robin after all report done
// Ports: Clock_pin, Resetn_pin (sync, active-low), io (slave: SW_pin/Done_core/Display_core in; SW_core/Display_pin/Active_core/Phase/Ops_left out)
module multicore_io_scheduler
  import multicore_io_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int OPS_PER_CORE = OPS_PER_CORE_DEF,
  parameter int SW_W = 5,
  parameter int DISP_W = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter logic [7:0] FINISH_PATTERN = FINISH_PATTERN_DEF
) (
  input logic Clock_pin,
  input logic Resetn_pin,
  multicore_io_scheduler_if.slave io
);
  logic [SW_W-1:0] sw_m, sw_s;
  logic [NUM_CORES-1:0] done_m, done_s;
  logic press, last;
  phase_e phase;
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .Clock_pin(Clock_pin),
    .Resetn_pin(Resetn_pin),
    .btn_pin(io.SW_pin[0]),
    .press(press)
  );
  assign last = io.Active_core == 3'(NUM_CORES - 1);
  assign io.Phase = phase;
  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      sw_m <= '0;
      sw_s <= '0;
      done_m <= '0;
      done_s <= '0;
      phase <= PH_INPUT;
      io.SW_core <= '0;
      io.Display_pin <= '0;
      io.Active_core <= '0;
      io.Ops_left <= 8'(OPS_PER_CORE);
    end else begin
      sw_m <= io.SW_pin;
      sw_s <= sw_m;
      done_m <= io.Done_core;
      done_s <= done_m;
      case (phase)
        PH_INPUT: begin
          io.SW_core <= {NUM_CORES{sw_s}};
          io.Display_pin <= io.Display_core[DISP_W-1:0];
          if (&done_s) begin
            phase <= PH_OUTPUT;
            io.Active_core <= '0;
            io.Ops_left <= 8'(OPS_PER_CORE);
          end
        end
        PH_OUTPUT: begin
          io.SW_core[io.Active_core*SW_W +: SW_W] <= sw_s;
          io.Display_pin <= io.Display_core[io.Active_core*DISP_W +: DISP_W];
          if (press && io.Ops_left != 8'd0) begin
            if (io.Ops_left > 8'd1) io.Ops_left <= io.Ops_left - 8'd1;
            else if (last) begin
              phase <= PH_FINISHED;
              io.Ops_left <= '0;
            end else begin
              io.Active_core <= io.Active_core + 3'd1;
              io.Ops_left <= 8'(OPS_PER_CORE);
            end
          end
        end
        default: begin
          io.Display_pin <= DISP_W'(FINISH_PATTERN);
          io.Ops_left <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicore_io_scheduler.sv
// tb_multicore_io_scheduler: directed checks of broadcast, grant rotation, debounce, finish and reset
module tb_multicore_io_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  multicore_io_scheduler_if #(.NUM_CORES(4), .SW_W(5), .DISP_W(8)) io ();
  multicore_io_scheduler dut (
    .Clock_pin(clk),
    .Resetn_pin(rst_n),
    .io(io)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_btn();
    io.SW_pin[0] = 1'b0;
    tick(40);
    io.SW_pin[0] = 1'b1;
    tick(40);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_phase"}, 32'(io.Phase), 32'd0);
    chk({tag, "_active"}, 32'(io.Active_core), 32'd0);
    chk({tag, "_ops"}, 32'(io.Ops_left), 32'd5);
    chk({tag, "_sw"}, 32'(io.SW_core), 32'd0);
    chk({tag, "_disp"}, 32'(io.Display_pin), 32'd0);
  endtask
  initial begin
    io.SW_pin = 5'b10110;
    io.Done_core = 4'b0000;
    io.Display_core = 32'h44332211;
    tick(2);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(3);
    chk("bcast", 32'(io.SW_core), 32'({4{5'b10110}}));
    chk("in_disp", 32'(io.Display_pin), 32'h11);
    chk("in_phase", 32'(io.Phase), 32'd0);
    io.Done_core = 4'b0111;
    tick(50);
    chk("partial_phase", 32'(io.Phase), 32'd0);
    chk("partial_bcast", 32'(io.SW_core), 32'({4{5'b10110}}));
    io.Done_core = 4'b1111;
    tick(3);
    chk("out_phase", 32'(io.Phase), 32'd1);
    chk("out_active", 32'(io.Active_core), 32'd0);
    chk("out_ops", 32'(io.Ops_left), 32'd5);
    chk("out_disp", 32'(io.Display_pin), 32'h11);
    io.SW_pin = 5'b10111;
    tick(30);
    chk("rise_no_press", 32'(io.Ops_left), 32'd5);
    chk("grant_sw", 32'(io.SW_core), 32'({5'b10110, 5'b10110, 5'b10110, 5'b10111}));
    press_btn();
    chk("press1_ops", 32'(io.Ops_left), 32'd4);
    io.SW_pin[0] = 1'b0;
    tick(5);
    io.SW_pin[0] = 1'b1;
    tick(40);
    chk("glitch_ops", 32'(io.Ops_left), 32'd4);
    repeat (4) press_btn();
    chk("core1_active", 32'(io.Active_core), 32'd1);
    chk("core1_ops", 32'(io.Ops_left), 32'd5);
    chk("core1_disp", 32'(io.Display_pin), 32'h22);
    repeat (5) press_btn();
    chk("core2_active", 32'(io.Active_core), 32'd2);
    chk("core2_disp", 32'(io.Display_pin), 32'h33);
    io.SW_pin = 5'b01101;
    tick(5);
    repeat (5) press_btn();
    chk("core3_active", 32'(io.Active_core), 32'd3);
    chk("core3_ops", 32'(io.Ops_left), 32'd5);
    chk("core3_disp", 32'(io.Display_pin), 32'h44);
    io.SW_pin = 5'b10011;
    tick(5);
    chk("core2_hold", 32'(io.SW_core[14:10]), 32'b01100);
    chk("core3_track", 32'(io.SW_core[19:15]), 32'b10011);
    repeat (4) press_btn();
    chk("core3_ops1", 32'(io.Ops_left), 32'd1);
    press_btn();
    chk("fin_phase", 32'(io.Phase), 32'd2);
    chk("fin_disp", 32'(io.Display_pin), 32'hA5);
    chk("fin_ops", 32'(io.Ops_left), 32'd0);
    chk("fin_active", 32'(io.Active_core), 32'd3);
    io.SW_pin = 5'b00001;
    press_btn();
    chk("fin2_phase", 32'(io.Phase), 32'd2);
    chk("fin2_ops", 32'(io.Ops_left), 32'd0);
    chk("fin2_disp", 32'(io.Display_pin), 32'hA5);
    chk("fin2_core2", 32'(io.SW_core[14:10]), 32'b01100);
    chk("fin2_core3", 32'(io.SW_core[19:15]), 32'b10010);
    rst_n = 1'b0;
    tick(1);
    chk_reset("rst_fin");
    rst_n = 1'b1;
    tick(3);
    chk("re_phase", 32'(io.Phase), 32'd1);
    tick(30);
    repeat (12) press_btn();
    chk("mid_active", 32'(io.Active_core), 32'd2);
    chk("mid_ops", 32'(io.Ops_left), 32'd3);
    rst_n = 1'b0;
    tick(1);
    chk_reset("rst_mid");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
